// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver: FSM state encoding,
// default timing parameters and ASCII byte values used around the BIOS link.
package uart_rx_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 434;
  localparam int unsigned DATA_BITS_DEF    = 8;

  typedef enum logic [2:0] {
    ST_RX_IDLE,
    ST_RX_START,
    ST_RX_DATA,
    ST_RX_STOP,
    ST_RX_BREAK
  } uart_rx_state_t;

  localparam logic [7:0] ASCII_UC_A = 8'h41;
  localparam logic [7:0] ASCII_UC_R = 8'h52;
  localparam logic [7:0] ASCII_LC_B = 8'h62;
  localparam logic [7:0] ASCII_LC_N = 8'h6E;
  localparam logic [7:0] ASCII_LC_O = 8'h6F;
  localparam logic [7:0] ASCII_LC_P = 8'h70;
  localparam logic [7:0] ASCII_LC_R = 8'h72;
  localparam logic [7:0] ASCII_LC_W = 8'h77;

endpackage

// File: rtl/uart_rx_if.sv
// Byte-stream valid/ready link from the UART receiver to its consumer.
interface uart_rx_if
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_BITS = DATA_BITS_DEF
);

  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for an asynchronous input pin, with a selectable
// reset value so idle-high and idle-low pins can share it.
module uart_rx_sync_2ff
  import uart_rx_pkg::*;
#(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-entry holding register on a
// valid/ready link, framing-error and overrun pulses, break suppression.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned DATA_BITS    = DATA_BITS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        i_rx,
  uart_rx_if.master   out_if,
  output logic        o_frame_err,
  output logic        o_overrun,
  output logic        o_busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  uart_rx_state_t       state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 frame_err_q;
  logic                 overrun_q;
  logic                 rx_s;

  uart_rx_sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (i_rx),
    .q_o (rx_s)
  );

  // Receive FSM plus holding register; everything here advances only on clk_en.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_RX_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (clk_en) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      if (valid_q && out_if.ready) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        ST_RX_IDLE: begin
          if (!rx_s) begin
            state_q <= ST_RX_START;
            cnt_q   <= '0;
          end
        end

        ST_RX_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            idx_q <= '0;
            state_q <= rx_s ? ST_RX_IDLE : ST_RX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_RX_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            if (idx_q == IDX_LAST) begin
              state_q <= ST_RX_STOP;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_RX_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (rx_s) begin
              // A consume on this same cycle frees the slot for the new byte.
              if (!valid_q || out_if.ready) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
              state_q <= ST_RX_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= ST_RX_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_RX_BREAK: begin
          if (rx_s) begin
            state_q <= ST_RX_IDLE;
          end
        end

        default: begin
          state_q <= ST_RX_IDLE;
        end
      endcase
    end
  end

  assign out_if.data  = data_q;
  assign out_if.valid = valid_q;
  assign o_frame_err  = frame_err_q;
  assign o_overrun    = overrun_q;
  assign o_busy       = (state_q != ST_RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed-plus-random bench for uart_rx at 16 clocks per bit, with a
// queue-based model of which bytes the consumer should see.
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int unsigned CPB = 16;
  localparam int unsigned DB  = 8;

  logic clk;
  logic rst;
  logic clk_en;
  logic i_rx;
  logic o_frame_err;
  logic o_overrun;
  logic o_busy;

  uart_rx_if #(.DATA_BITS(DB)) rx_if ();

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk         (clk),
    .rst         (rst),
    .clk_en      (clk_en),
    .i_rx        (i_rx),
    .out_if      (rx_if),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
    .o_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int unstable = 0;
  int rise_cyc = 0;
  int start_cyc = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  logic       prev_valid = 1'b0;
  logic       prev_acc = 1'b1;
  logic [7:0] prev_data = 8'h00;

  bit en_toggle = 1'b0;
  bit rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the link between edges: pulses, accepted bytes, data stability.
  always @(negedge clk) begin
    if (rst && clk_en) begin
      if (o_frame_err) fe_cnt++;
      if (o_overrun) ov_cnt++;
      if (rx_if.valid && rx_if.ready) got_q.push_back(rx_if.data);
    end
    if (rst && prev_valid && !prev_acc && rx_if.valid && (rx_if.data !== prev_data))
      unstable++;
    if (rx_if.valid && !prev_valid) rise_cyc = cyc;
    prev_valid = rx_if.valid;
    prev_data  = rx_if.data;
    prev_acc   = !rst || (clk_en && rx_if.valid && rx_if.ready);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clk_en = en_toggle ? ~clk_en : 1'b1;
    if (rand_ready) rx_if.ready = 1'($urandom_range(0, 1));
  endtask

  // Hold one line level for CPB enabled cycles.
  task automatic send_bit(input logic b);
    int n;
    i_rx = b;
    n = 0;
    while (n < int'(CPB)) begin
      if (clk_en) n++;
      tick();
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < int'(DB); i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  initial begin
    int fe0;
    int ov0;
    int lat;
    logic [7:0] rb;
    logic [7:0] part;

    rst = 1'b0;
    clk_en = 1'b1;
    i_rx = 1'b1;
    rx_if.ready = 1'b0;
    repeat (3) tick();

    check("rst_valid", 32'(rx_if.valid), 32'd0);
    check("rst_data", 32'(rx_if.data), 32'd0);
    check("rst_frame_err", 32'(o_frame_err), 32'd0);
    check("rst_overrun", 32'(o_overrun), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);

    rst = 1'b1;
    repeat (CPB) tick();

    // Clean byte held until the consumer takes it.
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(ASCII_LC_N, 1'b1);
    lat = rise_cyc - start_cyc;
    check("clean_valid", 32'(rx_if.valid), 32'd1);
    check("clean_data", 32'(rx_if.data), 32'(ASCII_LC_N));
    check("clean_latency_in_window", 32'(lat >= 153 && lat <= 155), 32'd1);
    repeat (20) tick();
    check("clean_hold_valid", 32'(rx_if.valid), 32'd1);
    check("clean_hold_data", 32'(rx_if.data), 32'(ASCII_LC_N));
    rx_if.ready = 1'b1;
    tick();
    rx_if.ready = 1'b0;
    check("clean_consumed", 32'(rx_if.valid), 32'd0);
    check("clean_no_err", 32'(fe_cnt - fe0 + ov_cnt - ov0), 32'd0);
    exp_q.push_back(ASCII_LC_N);
    send_bit(1'b1);

    // Short low glitch must be rejected at the mid-start check.
    fe0 = fe_cnt;
    i_rx = 1'b0;
    repeat (4) tick();
    i_rx = 1'b1;
    check("glitch_detected_busy", 32'(o_busy), 32'd1);
    for (int k = 0; k < int'(CPB / 2 + 3) && o_busy; k++) tick();
    check("glitch_busy_cleared", 32'(o_busy), 32'd0);
    check("glitch_no_valid", 32'(rx_if.valid), 32'd0);
    check("glitch_no_frame_err", 32'(fe_cnt - fe0), 32'd0);
    send_bit(1'b1);

    // Framing error followed by a held-low line, then a clean byte.
    rx_if.ready = 1'b1;
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(ASCII_LC_W, 1'b0);
    i_rx = 1'b0;
    repeat (40) tick();
    i_rx = 1'b1;
    repeat (CPB) tick();
    check("ferr_one_pulse", 32'(fe_cnt - fe0), 32'd1);
    check("ferr_no_valid", 32'(rx_if.valid), 32'd0);
    check("ferr_idle", 32'(o_busy), 32'd0);
    send_frame(ASCII_LC_R, 1'b1);
    exp_q.push_back(ASCII_LC_R);
    send_bit(1'b1);
    check("ferr_recover_count", 32'(got_q.size()), 32'(exp_q.size()));
    check("ferr_no_overrun", 32'(ov_cnt - ov0), 32'd0);

    // Overrun: second byte dropped, first retained.
    rx_if.ready = 1'b0;
    ov0 = ov_cnt;
    send_frame(ASCII_LC_B, 1'b1);
    send_frame(ASCII_LC_O, 1'b1);
    send_bit(1'b1);
    check("ovr_data_kept", 32'(rx_if.data), 32'(ASCII_LC_B));
    check("ovr_valid", 32'(rx_if.valid), 32'd1);
    check("ovr_one_pulse", 32'(ov_cnt - ov0), 32'd1);
    rx_if.ready = 1'b1;
    tick();
    rx_if.ready = 1'b0;
    check("ovr_consumed", 32'(rx_if.valid), 32'd0);
    exp_q.push_back(ASCII_LC_B);

    // Back-to-back frames, full-rate then half-rate enable.
    for (int pass = 0; pass < 2; pass++) begin
      en_toggle = (pass == 1);
      rx_if.ready = 1'b1;
      fe0 = fe_cnt; ov0 = ov_cnt;
      send_frame(ASCII_LC_N, 1'b1);
      send_frame(ASCII_LC_O, 1'b1);
      send_frame(ASCII_LC_P, 1'b1);
      exp_q.push_back(ASCII_LC_N);
      exp_q.push_back(ASCII_LC_O);
      exp_q.push_back(ASCII_LC_P);
      send_bit(1'b1);
      check($sformatf("b2b%0d_count", pass), 32'(got_q.size()), 32'(exp_q.size()));
      check($sformatf("b2b%0d_no_err", pass), 32'(fe_cnt - fe0 + ov_cnt - ov0), 32'd0);
    end
    en_toggle = 1'b0;
    clk_en = 1'b1;

    // Random bytes with a randomly stalling consumer.
    ov0 = ov_cnt;
    rand_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom);
      exp_q.push_back(rb);
      send_frame(rb, 1'b1);
    end
    rand_ready = 1'b0;
    rx_if.ready = 1'b1;
    send_bit(1'b1);
    check("rand_no_overrun", 32'(ov_cnt - ov0), 32'd0);

    // Reset in the middle of data bit 3, with a byte parked in the register.
    rx_if.ready = 1'b0;
    send_frame(ASCII_UC_A, 1'b1);
    send_bit(1'b1);
    check("midrst_parked", 32'(rx_if.valid), 32'd1);
    part = 8'h35;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(part[i]);
    i_rx = part[3];
    repeat (CPB / 2) tick();
    check("midrst_busy_before", 32'(o_busy), 32'd1);
    rst = 1'b0;
    i_rx = 1'b1;
    tick();
    check("midrst_valid", 32'(rx_if.valid), 32'd0);
    check("midrst_data", 32'(rx_if.data), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_pulses", 32'({o_frame_err, o_overrun}), 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    rx_if.ready = 1'b1;
    send_bit(1'b1);
    send_frame(ASCII_UC_R, 1'b1);
    exp_q.push_back(ASCII_UC_R);
    send_bit(1'b1);

    // Whole-run byte stream against the model.
    check("stream_len", 32'(got_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i])
      check($sformatf("stream_byte%0d", i),
            (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(exp_q[i]));
    check("data_stable_while_valid", 32'(unstable), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
